// File: rtl/mult_accumulator.sv
// mult_accumulator: sums a programmed number of unsigned products from the
//   upstream multiplier into a wide accumulator, then presents the sum.
// Latency: len+1 cycles from an accepted start to acc_valid when products
//   stream back to back. len=0 gives a zero result one cycle after start.
// Backpressure: prod_ready is high only while accumulating. The result is
//   held in DONE until acc_ready. Both handshake outputs are decoded from the
//   state register only, so no input feeds them combinationally.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   start, len          job start pulse and product count (sampled in IDLE)
//   prod_valid, prod    product stream in; prod_ready out
//   acc_out, ovf        accumulated sum (mod 2^ACC_W) and sticky carry flag
//   acc_valid           result valid out; acc_ready in
//   busy                high whenever a job is in progress or pending
//
// ACC_W must be >= PROD_W.

module mult_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic             ovf_q;

  logic             start_take;
  logic             prod_take;
  logic             last_prod;
  logic [ACC_W:0]   sum;

  // Handshake qualifiers. prod_ready is a pure state decode, so the
  // product handshake only needs the state and prod_valid.
  assign start_take = (state == IDLE) && start;
  assign prod_take  = (state == ACCUM) && prod_valid;
  assign last_prod  = (remaining == CNT_W'(1));

  // One extra bit captures the carry out of the accumulator MSB.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          // A zero-length job skips straight to presenting a zero result.
          state_nxt = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid && last_prod) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // start in this cycle is deliberately not looked at; the job
        // must be reissued once IDLE is reached.
        if (acc_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: accumulator, remaining count and sticky overflow.
  // Values are left untouched on the DONE->IDLE transition so the last
  // result stays visible until the next job is started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      remaining <= '0;
      ovf_q     <= 1'b0;
    end else if (start_take) begin
      acc       <= '0;
      remaining <= len;
      ovf_q     <= 1'b0;
    end else if (prod_take) begin
      acc       <= sum[ACC_W-1:0];
      remaining <= remaining - CNT_W'(1);
      ovf_q     <= ovf_q | sum[ACC_W];
    end
  end

  // Outputs: registers or state decodes only.
  assign prod_ready = (state == ACCUM);
  assign acc_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign acc_out    = acc;
  assign ovf        = ovf_q;

endmodule
